// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station and the ALU: opcode encoding,
// datapath widths, the CDB bundle, the RS entry layout and operand resolution.
package alu_reservation_station_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int TAG_WIDTH    = 4;
   localparam int OPCODE_WIDTH = 6;

   localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = 6'd0;
   localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC = 6'd1;
   localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'd2;
   localparam logic [OPCODE_WIDTH-1:0] OP_JALR  = 6'd3;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'd4;
   localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'd5;
   localparam logic [OPCODE_WIDTH-1:0] OP_BLT   = 6'd6;
   localparam logic [OPCODE_WIDTH-1:0] OP_BGE   = 6'd7;
   localparam logic [OPCODE_WIDTH-1:0] OP_BLTU  = 6'd8;
   localparam logic [OPCODE_WIDTH-1:0] OP_BGEU  = 6'd9;
   localparam logic [OPCODE_WIDTH-1:0] OP_LB    = 6'd10;
   localparam logic [OPCODE_WIDTH-1:0] OP_LH    = 6'd11;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'd12;
   localparam logic [OPCODE_WIDTH-1:0] OP_LBU   = 6'd13;
   localparam logic [OPCODE_WIDTH-1:0] OP_LHU   = 6'd14;
   localparam logic [OPCODE_WIDTH-1:0] OP_SB    = 6'd15;
   localparam logic [OPCODE_WIDTH-1:0] OP_SH    = 6'd16;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'd17;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'd18;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'd19;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = 6'd20;
   localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'd21;
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'd22;
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'd23;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLLI  = 6'd24;
   localparam logic [OPCODE_WIDTH-1:0] OP_SRLI  = 6'd25;
   localparam logic [OPCODE_WIDTH-1:0] OP_SRAI  = 6'd26;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 6'd27;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 6'd28;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLL   = 6'd29;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLT   = 6'd30;
   localparam logic [OPCODE_WIDTH-1:0] OP_SLTU  = 6'd31;
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = 6'd32;
   localparam logic [OPCODE_WIDTH-1:0] OP_SRL   = 6'd33;
   localparam logic [OPCODE_WIDTH-1:0] OP_SRA   = 6'd34;
   localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 6'd35;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 6'd36;

   typedef struct packed {
      logic                  valid;
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } cdb_t;

   typedef struct packed {
      logic                    busy;
      logic [OPCODE_WIDTH-1:0] op;
      logic [DATA_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0]   imm;
      logic [DATA_WIDTH-1:0]   v1;
      logic [DATA_WIDTH-1:0]   v2;
      logic [TAG_WIDTH-1:0]    q1;
      logic [TAG_WIDTH-1:0]    q2;
      logic                    r1;
      logic                    r2;
      logic [TAG_WIDTH-1:0]    tag;
   } rs_entry_t;

   typedef struct packed {
      logic                  ready;
      logic [DATA_WIDTH-1:0] value;
   } operand_t;

   // An operand already ready keeps its value; otherwise either CDB carrying its tag fills it.
   function automatic operand_t resolve_operand(input logic rdy,
                                                input logic [DATA_WIDTH-1:0] v,
                                                input logic [TAG_WIDTH-1:0] q,
                                                input cdb_t alu,
                                                input cdb_t lsb);
      operand_t res;
      res = '{ready: rdy, value: v};
      if (!rdy && alu.valid && alu.tag == q) begin
         res = '{ready: 1'b1, value: alu.data};
      end else if (!rdy && lsb.valid && lsb.tag == q) begin
         res = '{ready: 1'b1, value: lsb.data};
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_reservation_station_priority_select.sv
// Lowest-index set-bit finder: returns the index of the first asserted request
// and whether any request was asserted at all.
module rs_priority_select #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_found
);

   // Scanning downward lets the lowest set index be the last (winning) write.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = IDX_W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for integer/branch ops: buffers issued instructions, snoops
// both CDBs for missing operands and dispatches the lowest-index ready entry to the ALU.
module alu_reservation_station
   import alu_reservation_station_pkg::*;
#(
   parameter int RS_SIZE  = 8,
   parameter int TAG_W    = TAG_WIDTH,
   parameter int OPCODE_W = OPCODE_WIDTH,
   parameter int DATA_W   = DATA_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                is_clear,
   input  logic                is_issue,
   input  logic [OPCODE_W-1:0] op_from_dec,
   input  logic [DATA_W-1:0]   pc_from_dec,
   input  logic [DATA_W-1:0]   imm_from_dec,
   input  logic [DATA_W-1:0]   v1_from_dec,
   input  logic [DATA_W-1:0]   v2_from_dec,
   input  logic [TAG_W-1:0]    q1_from_dec,
   input  logic [TAG_W-1:0]    q2_from_dec,
   input  logic                rdy1_from_dec,
   input  logic                rdy2_from_dec,
   input  logic [TAG_W-1:0]    tag_from_dec,
   input  logic                alu_cdb_valid,
   input  logic [TAG_W-1:0]    alu_cdb_tag,
   input  logic [DATA_W-1:0]   alu_cdb_data,
   input  logic                lsb_cdb_valid,
   input  logic [TAG_W-1:0]    lsb_cdb_tag,
   input  logic [DATA_W-1:0]   lsb_cdb_data,
   output logic                is_full_to_dec,
   output logic [OPCODE_W-1:0] op_to_alu,
   output logic [DATA_W-1:0]   v1_to_alu,
   output logic [DATA_W-1:0]   v2_to_alu,
   output logic [DATA_W-1:0]   imm_to_alu,
   output logic [DATA_W-1:0]   pc_to_alu,
   output logic [TAG_W-1:0]    tag_to_alu,
   output logic                is_empty_to_alu
);

   localparam int IDX_W = $clog2(RS_SIZE);

   rs_entry_t           r_entries [RS_SIZE];
   logic [OPCODE_W-1:0] r_op;
   logic [DATA_W-1:0]   r_v1, r_v2, r_imm, r_pc;
   logic [TAG_W-1:0]    r_tag;
   logic                r_empty;

   logic [RS_SIZE-1:0]  w_busy, w_free, w_ready;
   logic [IDX_W-1:0]    w_freeIdx, w_readyIdx;
   logic                w_freeFound, w_readyFound;
   cdb_t                w_aluCdb, w_lsbCdb;
   operand_t            w_issueOp1, w_issueOp2;
   operand_t            w_wake1 [RS_SIZE];
   operand_t            w_wake2 [RS_SIZE];

   assign w_aluCdb = '{valid: alu_cdb_valid, tag: alu_cdb_tag, data: alu_cdb_data};
   assign w_lsbCdb = '{valid: lsb_cdb_valid, tag: lsb_cdb_tag, data: lsb_cdb_data};

   // Occupancy, readiness and per-entry wakeup are all derived from registered state.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         w_busy[i]  = r_entries[i].busy;
         w_ready[i] = r_entries[i].busy & r_entries[i].r1 & r_entries[i].r2;
         w_wake1[i] = resolve_operand(r_entries[i].r1, r_entries[i].v1, r_entries[i].q1,
                                      w_aluCdb, w_lsbCdb);
         w_wake2[i] = resolve_operand(r_entries[i].r2, r_entries[i].v2, r_entries[i].q2,
                                      w_aluCdb, w_lsbCdb);
      end
   end

   assign w_free         = ~w_busy;
   assign is_full_to_dec = &w_busy;
   assign w_issueOp1     = resolve_operand(rdy1_from_dec, v1_from_dec, q1_from_dec,
                                           w_aluCdb, w_lsbCdb);
   assign w_issueOp2     = resolve_operand(rdy2_from_dec, v2_from_dec, q2_from_dec,
                                           w_aluCdb, w_lsbCdb);

   rs_priority_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_freeSelect (
      .i_req  (w_free),
      .o_idx  (w_freeIdx),
      .o_found(w_freeFound)
   );

   rs_priority_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_readySelect (
      .i_req  (w_ready),
      .o_idx  (w_readyIdx),
      .o_found(w_readyFound)
   );

   // Free and dispatched entries are disjoint (non-busy vs busy), so issue, wakeup and
   // dispatch never write the same field of the same entry in one cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < RS_SIZE; i++) r_entries[i].busy <= 1'b0;
         r_op    <= '0;
         r_v1    <= '0;
         r_v2    <= '0;
         r_imm   <= '0;
         r_pc    <= '0;
         r_tag   <= '0;
         r_empty <= 1'b1;
      end else if (is_clear) begin
         for (int i = 0; i < RS_SIZE; i++) r_entries[i].busy <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_entries[i].busy) begin
               r_entries[i].v1 <= w_wake1[i].value;
               r_entries[i].r1 <= w_wake1[i].ready;
               r_entries[i].v2 <= w_wake2[i].value;
               r_entries[i].r2 <= w_wake2[i].ready;
            end
         end
         if (w_readyFound) begin
            r_op    <= r_entries[w_readyIdx].op;
            r_v1    <= r_entries[w_readyIdx].v1;
            r_v2    <= r_entries[w_readyIdx].v2;
            r_imm   <= r_entries[w_readyIdx].imm;
            r_pc    <= r_entries[w_readyIdx].pc;
            r_tag   <= r_entries[w_readyIdx].tag;
            r_empty <= 1'b0;
            r_entries[w_readyIdx].busy <= 1'b0;
         end else begin
            r_empty <= 1'b1;
         end
         if (is_issue && w_freeFound) begin
            r_entries[w_freeIdx] <= '{busy: 1'b1, op: op_from_dec, pc: pc_from_dec,
                                      imm: imm_from_dec, v1: w_issueOp1.value,
                                      v2: w_issueOp2.value, q1: q1_from_dec,
                                      q2: q2_from_dec, r1: w_issueOp1.ready,
                                      r2: w_issueOp2.ready, tag: tag_from_dec};
         end
      end
   end

   assign op_to_alu       = r_op;
   assign v1_to_alu       = r_v1;
   assign v2_to_alu       = r_v2;
   assign imm_to_alu      = r_imm;
   assign pc_to_alu       = r_pc;
   assign tag_to_alu      = r_tag;
   assign is_empty_to_alu = r_empty;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for the ALU reservation station: directed issues push expected
// dispatches, a negedge monitor pops and compares every dispatch the DUT presents.
module tb_alu_reservation_station;
   import alu_reservation_station_pkg::*;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        is_clear, is_issue;
   logic [5:0]  op_from_dec;
   logic [31:0] pc_from_dec, imm_from_dec, v1_from_dec, v2_from_dec;
   logic [3:0]  q1_from_dec, q2_from_dec, tag_from_dec;
   logic        rdy1_from_dec, rdy2_from_dec;
   logic        alu_cdb_valid, lsb_cdb_valid;
   logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
   logic [31:0] alu_cdb_data, lsb_cdb_data;
   logic        is_full_to_dec, is_empty_to_alu;
   logic [5:0]  op_to_alu;
   logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
   logic [3:0]  tag_to_alu;

   int   checks   = 0;
   int   failures = 0;
   exp_t expQ[$];
   exp_t monGot, monExp;

   alu_reservation_station #(.RS_SIZE(8), .TAG_W(4), .OPCODE_W(6), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .is_clear(is_clear), .is_issue(is_issue),
      .op_from_dec(op_from_dec), .pc_from_dec(pc_from_dec), .imm_from_dec(imm_from_dec),
      .v1_from_dec(v1_from_dec), .v2_from_dec(v2_from_dec),
      .q1_from_dec(q1_from_dec), .q2_from_dec(q2_from_dec),
      .rdy1_from_dec(rdy1_from_dec), .rdy2_from_dec(rdy2_from_dec),
      .tag_from_dec(tag_from_dec),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
      .is_full_to_dec(is_full_to_dec), .op_to_alu(op_to_alu),
      .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu), .imm_to_alu(imm_to_alu),
      .pc_to_alu(pc_to_alu), .tag_to_alu(tag_to_alu), .is_empty_to_alu(is_empty_to_alu)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc,
                                input logic [31:0] imm,
                                input logic [31:0] v1, input logic r1, input logic [3:0] q1,
                                input logic [31:0] v2, input logic r2, input logic [3:0] q2,
                                input logic [3:0] tag);
      is_issue      = 1'b1;
      op_from_dec   = op;
      pc_from_dec   = pc;
      imm_from_dec  = imm;
      v1_from_dec   = v1;
      rdy1_from_dec = r1;
      q1_from_dec   = q1;
      v2_from_dec   = v2;
      rdy2_from_dec = r2;
      q2_from_dec   = q2;
      tag_from_dec  = tag;
   endtask

   task automatic pushExpected(input logic [5:0] op, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [3:0] tag);
      expQ.push_back('{op: op, v1: v1, v2: v2, imm: imm, pc: pc, tag: tag});
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Every dispatch seen by the DUT must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && !is_empty_to_alu) begin
         monGot = '{op: op_to_alu, v1: v1_to_alu, v2: v2_to_alu, imm: imm_to_alu,
                    pc: pc_to_alu, tag: tag_to_alu};
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_dispatch actual=%h required=none", monGot);
         end else begin
            monExp = expQ.pop_front();
            if (monGot !== monExp) begin
               failures++;
               $display("[TB] FAIL dispatch actual=%h required=%h", monGot, monExp);
            end
         end
      end
   end

   initial begin
      rst = 1'b0; is_clear = 1'b0; is_issue = 1'b0;
      op_from_dec = '0; pc_from_dec = '0; imm_from_dec = '0;
      v1_from_dec = '0; v2_from_dec = '0; q1_from_dec = '0; q2_from_dec = '0;
      rdy1_from_dec = 1'b0; rdy2_from_dec = 1'b0; tag_from_dec = '0;
      alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_data = '0;
      lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_data = '0;
      tick();
      tick();
      checkOutput("reset_empty", 64'(is_empty_to_alu), 64'd1);
      checkOutput("reset_full", 64'(is_full_to_dec), 64'd0);
      checkOutput("reset_op", 64'(op_to_alu), 64'd0);
      checkOutput("reset_v1", 64'(v1_to_alu), 64'd0);
      checkOutput("reset_tag", 64'(tag_to_alu), 64'd0);
      rst = 1'b1;
      tick();

      $display("[TB] test1 ready ADD");
      applyStimulus(OP_ADD, 32'h100, 32'h11, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
      pushExpected(OP_ADD, 32'd5, 32'd7, 32'h11, 32'h100, 4'd3);
      tick();
      is_issue = 1'b0;
      checkOutput("t1_not_yet", 64'(is_empty_to_alu), 64'd1);
      tick();
      checkOutput("t1_dispatch", 64'(is_empty_to_alu), 64'd0);
      tick();
      checkOutput("t1_after", 64'(is_empty_to_alu), 64'd1);

      $display("[TB] test2 ALU CDB wakeup");
      applyStimulus(OP_SUB, 32'h104, 32'h22, 32'hDEAD, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0, 4'd4);
      pushExpected(OP_SUB, 32'd10, 32'd1, 32'h22, 32'h104, 4'd4);
      tick();
      is_issue = 1'b0;
      checkOutput("t2_wait", 64'(is_empty_to_alu), 64'd1);
      alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'd10;
      tick();
      alu_cdb_valid = 1'b0;
      checkOutput("t2_not_same_cycle", 64'(is_empty_to_alu), 64'd1);
      tick();
      checkOutput("t2_dispatch", 64'(is_empty_to_alu), 64'd0);
      tick();

      $display("[TB] test3 LSB capture at issue");
      applyStimulus(OP_XOR, 32'h108, 32'h33, 32'd3, 1'b1, 4'd0, 32'hBEEF, 1'b0, 4'd6, 4'd5);
      lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd6; lsb_cdb_data = 32'hFFFF_FFFF;
      pushExpected(OP_XOR, 32'd3, 32'hFFFF_FFFF, 32'h33, 32'h108, 4'd5);
      tick();
      is_issue = 1'b0; lsb_cdb_valid = 1'b0;
      tick();
      checkOutput("t3_dispatch", 64'(is_empty_to_alu), 64'd0);
      tick();

      $display("[TB] test4 fill and drain");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(OP_ADD, 32'(i * 4), 32'(i), 32'h0, 1'b0, 4'd9, 32'(i), 1'b1, 4'd0, 4'(i));
         pushExpected(OP_ADD, 32'h99, 32'(i), 32'(i), 32'(i * 4), 4'(i));
         tick();
      end
      is_issue = 1'b0;
      checkOutput("t4_full", 64'(is_full_to_dec), 64'd1);
      applyStimulus(OP_OR, 32'h200, 32'h0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd8);
      tick();
      is_issue = 1'b0;
      checkOutput("t4_full_after_drop", 64'(is_full_to_dec), 64'd1);
      alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd9; alu_cdb_data = 32'h99;
      tick();
      alu_cdb_valid = 1'b0;
      checkOutput("t4_full_at_wakeup", 64'(is_full_to_dec), 64'd1);
      checkOutput("t4_empty_at_wakeup", 64'(is_empty_to_alu), 64'd1);
      tick();
      checkOutput("t4_first_dispatch", 64'(is_empty_to_alu), 64'd0);
      checkOutput("t4_not_full", 64'(is_full_to_dec), 64'd0);
      for (int k = 1; k < 8; k++) begin
         tick();
         checkOutput($sformatf("t4_dispatch_%0d", k), 64'(is_empty_to_alu), 64'd0);
      end
      tick();
      checkOutput("t4_drained", 64'(is_empty_to_alu), 64'd1);

      $display("[TB] test5 flush");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_AND, 32'h300, 32'h0, 32'h0, 1'b0, 4'd15, 32'd1, 1'b1, 4'd0, 4'(10 + i));
         tick();
      end
      applyStimulus(OP_SLT, 32'h310, 32'h0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd13);
      is_clear = 1'b1;
      tick();
      is_issue = 1'b0; is_clear = 1'b0;
      checkOutput("t5_empty", 64'(is_empty_to_alu), 64'd1);
      checkOutput("t5_not_full", 64'(is_full_to_dec), 64'd0);
      alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd15; alu_cdb_data = 32'h55;
      tick();
      alu_cdb_valid = 1'b0;
      tick();
      checkOutput("t5_no_dispatch", 64'(is_empty_to_alu), 64'd1);

      $display("[TB] test6 reset mid-stream");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_SRL, 32'h400, 32'h0, 32'h0, 1'b0, 4'd14, 32'd1, 1'b1, 4'd0, 4'(1 + i));
         tick();
      end
      applyStimulus(OP_SLL, 32'h410, 32'h0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd4);
      tick();
      is_issue = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("t6_empty", 64'(is_empty_to_alu), 64'd1);
      checkOutput("t6_op", 64'(op_to_alu), 64'd0);
      checkOutput("t6_v1", 64'(v1_to_alu), 64'd0);
      checkOutput("t6_v2", 64'(v2_to_alu), 64'd0);
      checkOutput("t6_imm", 64'(imm_to_alu), 64'd0);
      checkOutput("t6_pc", 64'(pc_to_alu), 64'd0);
      checkOutput("t6_tag", 64'(tag_to_alu), 64'd0);
      checkOutput("t6_full", 64'(is_full_to_dec), 64'd0);
      alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd14; alu_cdb_data = 32'h77;
      tick();
      alu_cdb_valid = 1'b0;
      tick();
      checkOutput("t6_no_dispatch", 64'(is_empty_to_alu), 64'd1);
      applyStimulus(OP_ADDI, 32'h500, 32'hFFF, 32'd8, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd7);
      pushExpected(OP_ADDI, 32'd8, 32'd0, 32'hFFF, 32'h500, 4'd7);
      tick();
      is_issue = 1'b0;
      tick();
      checkOutput("t6_new_dispatch", 64'(is_empty_to_alu), 64'd0);
      tick();
      tick();

      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station for integer/branch ops, directly upstream of the ALU. It buffers instructions issued by the decoder with their operand values or ROB tags, and snoops the ALU and LSB result broadcasts (CDB) to fill missing operands. Each cycle it dispatches the lowest-index entry with both operands ready, through an output register, to the ALU. The ALU is combinational, so the ALU result reaches the ROB in the same cycle as dispatch.

Parameters:
RS_SIZE, 8, number of entries (power of 2, ≥2)
TAG_W, 4, ROB tag width
OPCODE_W, 6, opcode width (matches the shared opcode encoding)
DATA_W, 32, operand/immediate/pc width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
is_clear  in  1  misprediction flush from ROB
is_issue  in  1  decoder issues one instruction this cycle
op_from_dec  in  OPCODE_W  opcode
pc_from_dec  in  DATA_W  instruction pc
imm_from_dec  in  DATA_W  raw immediate
v1_from_dec / v2_from_dec  in  DATA_W  operand values (valid when rdy bit = 1)
q1_from_dec / q2_from_dec  in  TAG_W  producer ROB tag (used when rdy bit = 0)
rdy1_from_dec / rdy2_from_dec  in  1  operand already available
tag_from_dec  in  TAG_W  destination ROB tag
alu_cdb_valid, alu_cdb_tag, alu_cdb_data  in  1/TAG_W/DATA_W  ALU result broadcast
lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data  in  1/TAG_W/DATA_W  LSB result broadcast
is_full_to_dec  out  1  no free entry
op_to_alu  out  OPCODE_W  dispatched opcode
v1_to_alu / v2_to_alu / imm_to_alu / pc_to_alu  out  DATA_W  dispatched operands
tag_to_alu  out  TAG_W  dispatched ROB tag, passed with the ALU result to the ROB
is_empty_to_alu  out  1  1 = no valid dispatch this cycle

Behaviour:
- Entry fields: busy, op, pc, imm, v1, v2, q1, q2, r1, r2, tag.
- Reset (rst=0 at a posedge):
  - all busy flags cleared.
  - is_empty_to_alu=1; all other outputs 0.
  - is_full_to_dec=0.
  - overrides any in-flight issue, dispatch or wakeup.
- is_full_to_dec: combinational, 1 when all RS_SIZE entries are busy. The decoder must not issue while it is 1; an issue while full is dropped with no state change.
- Allocation: an issue writes the lowest-index non-busy entry, sampled at the start of the cycle.
- Issue-cycle capture: for each operand with rdy=0, if a CDB valid in the same cycle carries a matching tag, the entry stores that data with r=1.
- Wakeup: every busy entry with r=0 and q equal to a valid CDB tag takes that data and sets r=1 at the edge. ALU and LSB are checked independently; the two CDBs never carry equal tags.
- Select: the lowest-index busy entry with r1&r2=1, evaluated on registered state only.
  - An entry woken or issued in cycle N is eligible for dispatch at the earliest in cycle N+1.
- Dispatch: the selected entry's fields are loaded into the output registers at the edge, is_empty_to_alu<=0, and the entry's busy is cleared at the same edge.
  - With no ready entry: is_empty_to_alu<=1 and the other outputs hold their values.
  - Latency: issue with both operands ready at edge N → is_empty_to_alu=0 during cycle N+1.
- Simultaneous issue and dispatch:
  - allowed; the freed entry is reusable from the next cycle only.
  - a full RS that dispatches still reports full in that cycle.
- Flush (is_clear=1):
  - all busy cleared and is_empty_to_alu<=1 at the edge.
  - issue and dispatch in that cycle are discarded.
  - priority order: rst > is_clear > issue/dispatch.
- imm is passed unmodified; the ALU does sign extension.
- Throughput: 1 issue + 1 dispatch per cycle.

Decomposition:
- Shared package:
  - opcode constants (LUI…AND), so RS and ALU share one encoding.
  - Data/Pc/Opcode width constants.
  - CDB bundle typedef (valid, tag, data).
  - RS entry typedef.
- One natural sub-module: rs_priority_select. Generic lowest-index-set-bit finder returning index + found flag; instanced twice (free-entry search and ready-entry search).

Test Plan:
1. Issue ADD (op=ADD, v1=5, v2=7, both rdy, tag=3) at cycle 0 → cycle 1: is_empty_to_alu=0, op=ADD, v1=5, v2=7, tag_to_alu=3; cycle 2: is_empty_to_alu=1.
2. Issue SUB with rdy1=0, q1=2, v2=1; alu_cdb_valid tag=2 data=10 at cycle 3 → dispatch at cycle 4 with v1=10, v2=1; nothing dispatched before cycle 4.
3. Issue with q2=6 in the same cycle lsb_cdb_valid tag=6 data=0xFFFF_FFFF → entry captured ready; dispatch next cycle with v2=0xFFFF_FFFF.
4. Fill 8 non-ready entries (q1=9) → is_full_to_dec=1; a ninth issue is dropped; alu_cdb tag=9 → entries 0..7 dispatch in index order on 8 consecutive cycles; is_full_to_dec falls to 0 the cycle after the first dispatch.
5. Three busy entries, is_clear=1 coincident with an issue → next cycle: 0 busy, is_empty_to_alu=1, is_full_to_dec=0; the issued op is never dispatched.
6. Assert rst=0 for one cycle mid-stream with 4 busy entries and a pending dispatch → all outputs at their reset values, no dispatch after reset until a new issue.
